traffic_light_ctrl: RTL



---
 rtl/traffic_pkg.sv | 40 ++++
 rtl/sec_prescaler.sv | 33 +++
 rtl/traffic_light_ctrl.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/traffic_pkg.sv
// traffic_pkg
// Shared types and helpers for the intersection sequencer.
//   state_t  : phase encoding, also exported on the debug `phase` port
//   RED/YELLOW/GREEN : one-hot {red, yellow, green} lamp patterns
//   bcd_dec  : decrement a two-digit BCD value by one
//   to_bcd   : convert a 0..99 integer to two-digit BCD
package traffic_pkg;

  typedef enum logic [2:0] {
    NS_GREEN  = 3'd0,
    NS_YELLOW = 3'd1,
    ALL_RED_1 = 3'd2,
    EW_GREEN  = 3'd3,
    EW_YELLOW = 3'd4,
    ALL_RED_2 = 3'd5,
    WALK      = 3'd6
  } state_t;

  localparam logic [2:0] RED    = 3'b100;
  localparam logic [2:0] YELLOW = 3'b010;
  localparam logic [2:0] GREEN  = 3'b001;

  // Units borrow from 0 to 9 and take one off the tens digit (0x10 -> 0x09).
  // Never called with 0x00: the controller reloads at 0x01 instead.
  function automatic logic [7:0] bcd_dec(input logic [7:0] v);
    if (v[3:0] == 4'd0) begin
      return {v[7:4] - 4'd1, 4'd9};
    end
    return {v[7:4], v[3:0] - 4'd1};
  endfunction

  function automatic logic [7:0] to_bcd(input int unsigned sec);
    logic [3:0] tens;
    logic [3:0] units;
    tens  = 4'((sec / 10) % 10);
    units = 4'(sec % 10);
    return {tens, units};
  endfunction

endpackage

// File: rtl/sec_prescaler.sv
// sec_prescaler
// Divides the system clock down to a one-cycle pulse once per second.
//   clk     : system clock
//   rst_n   : synchronous active-low reset
//   restart : forces the count back to zero so the next phase starts
//             with a full second
//   tick    : high for the single cycle in which the count is at its top
module sec_prescaler #(
  parameter int unsigned TICKS_PER_SEC = 50_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  output logic tick
);

  localparam int unsigned CW = (TICKS_PER_SEC > 2) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICKS_PER_SEC - 1);

  logic [CW-1:0] count;

  // Free-running modulo counter; wraps at the top value or on restart.
  always_ff @(posedge clk) begin
    if (!rst_n || restart || (count == LAST)) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

  assign tick = (count == LAST);

endmodule

// File: rtl/traffic_light_ctrl.sv
// traffic_light_ctrl
// Moore sequencer for a two-way intersection with an optional pedestrian
// walk phase, plus a BCD countdown of seconds left in the current phase.
//   clk       : system clock
//   rst_n     : synchronous active-low reset, restarts in ALL_RED_2
//   ped_req   : pedestrian request level (already synchronised/debounced)
//   ns_light  : north-south {red, yellow, green}, one-hot
//   ew_light  : east-west {red, yellow, green}, one-hot
//   walk      : walk indicator, high only in WALK
//   countdown : BCD seconds remaining, [7:4] tens, [3:0] units
//   phase     : raw state encoding for debug LEDs
module traffic_light_ctrl
  import traffic_pkg::*;
#(
  parameter int unsigned TICKS_PER_SEC = 50_000_000,
  parameter int unsigned GREEN_SEC     = 10,
  parameter int unsigned YELLOW_SEC    = 3,
  parameter int unsigned ALL_RED_SEC   = 1,
  parameter int unsigned WALK_SEC      = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ped_req,
  output logic [2:0] ns_light,
  output logic [2:0] ew_light,
  output logic       walk,
  output logic [7:0] countdown,
  output logic [2:0] phase
);

  if (TICKS_PER_SEC < 2 ||
      GREEN_SEC   < 1 || GREEN_SEC   > 99 ||
      YELLOW_SEC  < 1 || YELLOW_SEC  > 99 ||
      ALL_RED_SEC < 1 || ALL_RED_SEC > 99 ||
      WALK_SEC    < 1 || WALK_SEC    > 99) begin : g_param_error
    $error("traffic_light_ctrl: timing parameter out of range");
  end

  localparam logic [7:0] GREEN_BCD   = to_bcd(GREEN_SEC);
  localparam logic [7:0] YELLOW_BCD  = to_bcd(YELLOW_SEC);
  localparam logic [7:0] ALL_RED_BCD = to_bcd(ALL_RED_SEC);
  localparam logic [7:0] WALK_BCD    = to_bcd(WALK_SEC);

  state_t     state;
  state_t     state_next;
  logic [7:0] remaining;
  logic       ped_pending;
  logic       sec_tick;
  logic       phase_done;

  // The last second of a phase ends when the tick arrives with one second
  // left; the counter reloads instead of showing 0x00.
  assign phase_done = sec_tick && (remaining == 8'h01);

  sec_prescaler #(
    .TICKS_PER_SEC(TICKS_PER_SEC)
  ) u_prescaler (
    .clk    (clk),
    .rst_n  (rst_n),
    .restart(phase_done),
    .tick   (sec_tick)
  );

  function automatic logic [7:0] duration_of(input state_t s);
    case (s)
      NS_GREEN, EW_GREEN:   return GREEN_BCD;
      NS_YELLOW, EW_YELLOW: return YELLOW_BCD;
      WALK:                 return WALK_BCD;
      default:              return ALL_RED_BCD;
    endcase
  endfunction

  // State register; reset lands in the clearance phase before NS_GREEN so
  // the intersection always starts from all-red.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ALL_RED_2;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and lamp decode. Lamps depend on the state register only.
  always_comb begin
    state_next = state;
    ns_light   = RED;
    ew_light   = RED;
    walk       = 1'b0;

    if (phase_done) begin
      case (state)
        NS_GREEN:  state_next = NS_YELLOW;
        NS_YELLOW: state_next = ALL_RED_1;
        ALL_RED_1: state_next = EW_GREEN;
        EW_GREEN:  state_next = EW_YELLOW;
        EW_YELLOW: state_next = ALL_RED_2;
        ALL_RED_2: state_next = ped_pending ? WALK : NS_GREEN;
        default:   state_next = NS_GREEN;
      endcase
    end

    case (state)
      NS_GREEN:  ns_light = GREEN;
      NS_YELLOW: ns_light = YELLOW;
      EW_GREEN:  ew_light = GREEN;
      EW_YELLOW: ew_light = YELLOW;
      WALK:      walk     = 1'b1;
      default:   ;
    endcase
  end

  // Seconds-remaining counter kept directly in BCD so it can drive the
  // seven-segment encoders without conversion.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      remaining <= ALL_RED_BCD;
    end else if (phase_done) begin
      remaining <= duration_of(state_next);
    end else if (sec_tick) begin
      remaining <= bcd_dec(remaining);
    end
  end

  // Pedestrian latch. Entering WALK wins over a request in the same cycle,
  // and requests made while walking are ignored, so a held button produces
  // one WALK per full cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ped_pending <= 1'b0;
    end else if (phase_done && (state_next == WALK)) begin
      ped_pending <= 1'b0;
    end else if (ped_req && (state != WALK)) begin
      ped_pending <= 1'b1;
    end
  end

  assign countdown = remaining;
  assign phase     = state;

endmodule
